// File: rtl/m_wb_uart.sv
// Wishbone-classic slave 8N1 UART: one-byte TX holding register feeding a shifter,
// one-byte RX buffer with valid/overrun/framing-error flags, fixed CLKDIV-cycle bit period.
module m_wb_uart #(
  parameter int CLKDIV = 104,
  parameter int DIVW   = 12
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        rxirq
);

  localparam logic [DIVW-1:0] DIV_FULL = DIVW'(CLKDIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLKDIV / 2 - 1);
  localparam logic [DIVW-1:0] CNT_ONE  = DIVW'(1);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  // Bus side
  logic        ack_reg;
  logic [31:0] dat_reg;
  logic        data_wr_blocked;
  logic        accept;
  logic        wr_data;
  logic        rd_data;
  logic        wr_stat;
  logic        rd_stat;
  logic [4:0]  status;
  logic        unused_dat_hi;

  // Transmitter
  tx_state_t       tx_state_reg, tx_state_next;
  logic            txfull_reg;
  logic [7:0]      holding_reg;
  logic [9:0]      shifter_reg;
  logic [3:0]      bitcnt_reg;
  logic [DIVW-1:0] txcnt_reg;
  logic            tx_bit_end;
  logic            tx_last_bit;
  logic            tx_load;
  logic            tx_shift;

  // Receiver
  rx_state_t       rx_state_reg, rx_state_next;
  logic            rx_meta_reg;
  logic            rs_reg;
  logic [DIVW-1:0] rxcnt_reg;
  logic [2:0]      rxbit_reg;
  logic [7:0]      rxshift_reg;
  logic [7:0]      rxbuf_reg;
  logic            rxvalid_reg;
  logic            overrun_reg;
  logic            framerr_reg;
  logic            rx_cnt_end;
  logic            rx_sample;
  logic            rx_good;
  logic            rx_ferr;

  // A DATA write is held off (no ACK) while the holding register is still full.
  assign data_wr_blocked = WE_I && !ADR_I && txfull_reg;
  assign accept          = STB_I && !ack_reg && !data_wr_blocked;
  assign wr_data         = accept &&  WE_I && !ADR_I;
  assign rd_data         = accept && !WE_I && !ADR_I;
  assign wr_stat         = accept &&  WE_I &&  ADR_I;
  assign rd_stat         = accept && !WE_I &&  ADR_I;
  assign unused_dat_hi   = ^DAT_I[31:8];

  assign status = {framerr_reg, overrun_reg, rxvalid_reg, (tx_state_reg == TX_SHIFT), txfull_reg};

  assign ACK_O   = ack_reg;
  assign DAT_O   = dat_reg;
  assign rxirq   = rxvalid_reg;
  assign usartTX = (tx_state_reg == TX_SHIFT) ? shifter_reg[0] : 1'b1;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_reg <= 1'b0;
      dat_reg <= '0;
    end else begin
      ack_reg <= accept;
      if (rd_data) begin
        dat_reg <= {24'h0, rxbuf_reg};
      end else if (rd_stat) begin
        dat_reg <= {27'h0, status};
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      txfull_reg  <= 1'b0;
      holding_reg <= '0;
    end else if (wr_data) begin
      holding_reg <= DAT_I[7:0];
      txfull_reg  <= 1'b1;
    end else if (tx_load) begin
      txfull_reg  <= 1'b0;
    end
  end

  // ---------------- Transmitter ----------------
  assign tx_bit_end  = (txcnt_reg == '0);
  assign tx_last_bit = (bitcnt_reg == 4'd9);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state_reg <= TX_IDLE;
    end else begin
      tx_state_reg <= tx_state_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_load       = 1'b0;
    tx_shift      = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (txfull_reg) begin
          tx_load       = 1'b1;
          tx_state_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_bit_end) begin
          if (!tx_last_bit) begin
            tx_shift = 1'b1;
          end else if (txfull_reg) begin
            // Reload on the stop bit's final edge so frames run back to back.
            tx_load = 1'b1;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      shifter_reg <= '0;
      bitcnt_reg  <= '0;
      txcnt_reg   <= '0;
    end else if (tx_load) begin
      shifter_reg <= {1'b1, holding_reg, 1'b0};
      bitcnt_reg  <= '0;
      txcnt_reg   <= DIV_FULL;
    end else if (tx_shift) begin
      shifter_reg <= {1'b1, shifter_reg[9:1]};
      bitcnt_reg  <= bitcnt_reg + 4'd1;
      txcnt_reg   <= DIV_FULL;
    end else if (tx_state_reg == TX_SHIFT && !tx_bit_end) begin
      txcnt_reg   <= txcnt_reg - CNT_ONE;
    end
  end

  // ---------------- Receiver ----------------
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_meta_reg <= 1'b1;
      rs_reg      <= 1'b1;
    end else begin
      rx_meta_reg <= usartRX;
      rs_reg      <= rx_meta_reg;
    end
  end

  assign rx_cnt_end = (rxcnt_reg == '0);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_state_reg <= RX_IDLE;
    end else begin
      rx_state_reg <= rx_state_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_sample     = 1'b0;
    rx_good       = 1'b0;
    rx_ferr       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rs_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // Line back high at mid-start-bit means it was only a glitch.
        if (rx_cnt_end) rx_state_next = rs_reg ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_cnt_end) begin
          rx_sample = 1'b1;
          if (rxbit_reg == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_end) begin
          if (rs_reg) begin
            rx_good       = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            rx_ferr       = 1'b1;
            rx_state_next = RX_WAITHI;
          end
        end
      end
      RX_WAITHI: begin
        if (rs_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rxcnt_reg   <= '0;
      rxbit_reg   <= '0;
      rxshift_reg <= '0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          rxcnt_reg <= DIV_HALF;
          rxbit_reg <= '0;
        end
        RX_START, RX_DATA, RX_STOP: begin
          rxcnt_reg <= rx_cnt_end ? DIV_FULL : (rxcnt_reg - CNT_ONE);
        end
        default: rxcnt_reg <= rxcnt_reg;
      endcase
      if (rx_sample) begin
        rxshift_reg <= {rs_reg, rxshift_reg[7:1]};
        rxbit_reg   <= rxbit_reg + 3'd1;
      end
    end
  end

  // A DATA read in the same cycle as a completed byte frees the buffer first,
  // so the new byte lands without raising overrun.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rxbuf_reg   <= '0;
      rxvalid_reg <= 1'b0;
      overrun_reg <= 1'b0;
      framerr_reg <= 1'b0;
    end else begin
      if (rx_good && (!rxvalid_reg || rd_data)) begin
        rxbuf_reg   <= rxshift_reg;
        rxvalid_reg <= 1'b1;
      end else if (rd_data) begin
        rxvalid_reg <= 1'b0;
      end
      if (rx_good && rxvalid_reg && !rd_data) begin
        overrun_reg <= 1'b1;
      end else if (wr_stat && DAT_I[3]) begin
        overrun_reg <= 1'b0;
      end
      if (rx_ferr) begin
        framerr_reg <= 1'b1;
      end else if (wr_stat && DAT_I[4]) begin
        framerr_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m_wb_uart.sv
// Self-checking bench for m_wb_uart at CLKDIV=4: directed TX/RX/reset sequences,
// an RX register table, and randomized traffic against a behavioural model.
module tb_m_wb_uart;

  localparam int CLKDIV = 4;
  localparam int FRAME  = 10 * CLKDIV;

  localparam int OP_FRAME   = 0;
  localparam int OP_RD_DATA = 1;
  localparam int OP_RD_STAT = 2;
  localparam int OP_WR_STAT = 3;
  localparam int OP_IRQ     = 4;

  typedef logic [7:0] u8_t;
  typedef struct {
    int          op;
    logic [7:0]  data;
    logic        stop;
    logic [31:0] exp;
  } rx_vec_t;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic        ADR_I = 1'b0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        usartRX = 1'b1;
  logic        usartTX;
  logic        rxirq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic mon_en = 1'b0;
  int   tr_cyc[$];
  logic tr_bit[$];

  // Behavioural model of the receive-side register state
  logic [7:0] m_rxbuf;
  logic       m_rxvalid;
  logic       m_overrun;
  logic       m_framerr;

  m_wb_uart #(.CLKDIV(CLKDIV), .DIVW(12)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .STB_I   (STB_I),
    .WE_I    (WE_I),
    .ADR_I   (ADR_I),
    .DAT_I   (DAT_I),
    .DAT_O   (DAT_O),
    .ACK_O   (ACK_O),
    .usartRX (usartRX),
    .usartTX (usartTX),
    .rxirq   (rxirq)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(negedge CLK_I) begin
    if (mon_en) begin
      tr_cyc.push_back(cyc);
      tr_bit.push_back(usartTX);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("check %s = 0x%08h", name, act);
    end
  endtask

  task automatic wb(input logic we, input logic adr, input logic [31:0] wd,
                    output logic [31:0] rd, output int waited, output int ack_cyc);
    @(negedge CLK_I);
    STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
    waited = 0;
    @(negedge CLK_I);
    while (ACK_O !== 1'b1 && waited < 500) begin
      waited++;
      @(negedge CLK_I);
    end
    ack_cyc = cyc;
    rd = DAT_O;
    if (ACK_O !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=no_ack required=ack");
    end
    STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
  endtask

  task automatic bus_write(input logic adr, input logic [31:0] d);
    logic [31:0] r;
    int w, c;
    wb(1'b1, adr, d, r, w, c);
  endtask

  task automatic bus_read(input logic adr, output logic [31:0] r);
    int w, c;
    wb(1'b0, adr, 32'h0, r, w, c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_I);
      usartRX = bits[i];
      repeat (CLKDIV - 1) @(negedge CLK_I);
    end
    @(negedge CLK_I);
    usartRX = 1'b1;
    repeat (2 * CLKDIV) @(negedge CLK_I);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_framerr = 1'b1;
    else if (m_rxvalid) m_overrun = 1'b1;
    else begin
      m_rxbuf   = b;
      m_rxvalid = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_status();
    return {27'h0, m_framerr, m_overrun, m_rxvalid, 2'b00};
  endfunction

  // Compares the recorded line against the ideal 8N1 waveform of the byte list,
  // frames back to back, followed by one idle-high sample.
  task automatic check_tx_trace(input string name, input u8_t bytes[$], input int exp_start);
    int first, n, bad, k, f;
    logic expb;
    first = -1;
    for (int i = 0; i < tr_bit.size(); i++) begin
      if (tr_bit[i] === 1'b0) begin
        first = i;
        break;
      end
    end
    check({name, "_start_cycle"}, (first >= 0) ? tr_cyc[first] : -1, exp_start);
    if (first >= 0) begin
      n = bytes.size() * FRAME;
      bad = 0;
      for (int i = 0; i <= n; i++) begin
        if (i == n) expb = 1'b1;
        else begin
          f = i / FRAME;
          k = (i % FRAME) / CLKDIV;
          expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[f][k-1];
        end
        if (first + i >= tr_bit.size() || tr_bit[first + i] !== expb) bad++;
      end
      check({name, "_bad_samples"}, bad, 0);
    end
  endtask

  initial begin
    rx_vec_t     vecs[$];
    rx_vec_t     v;
    logic [31:0] r;
    int          w, c1, c2, c3;
    u8_t         bl[$];

    // ---------------- Reset state ----------------
    #1 RST_I = 1'b1;
    #1;
    check("reset_usartTX", usartTX, 1);
    check("reset_ack", ACK_O, 0);
    check("reset_dat_o", DAT_O, 0);
    check("reset_rxirq", rxirq, 0);
    idle(3);
    RST_I = 1'b0;
    bus_read(1'b1, r);
    check("reset_status", r, 0);

    // ---------------- TX single byte ----------------
    tr_cyc.delete(); tr_bit.delete();
    mon_en = 1'b1;
    wb(1'b1, 1'b0, 32'h0000_00A5, r, w, c1);
    check("tx1_ack_wait", w, 0);
    bus_read(1'b1, r);
    check("tx1_status_busy", r, 32'h02);
    idle(FRAME + 4);
    bus_read(1'b1, r);
    check("tx1_status_idle", r, 32'h00);
    mon_en = 1'b0;
    bl = '{8'hA5};
    check_tx_trace("tx1", bl, c1 + 1);

    // ---------------- TX back to back ----------------
    tr_cyc.delete(); tr_bit.delete();
    mon_en = 1'b1;
    wb(1'b1, 1'b0, 32'h55, r, w, c1);
    wb(1'b1, 1'b0, 32'h0F, r, w, c2);
    check("tx2_second_ack_wait", w, 0);
    wb(1'b1, 1'b0, 32'hFF, r, w, c3);
    check("tx2_third_ack_cycle", c3, c1 + 1 + FRAME + 1);
    idle(3 * FRAME + 4);
    mon_en = 1'b0;
    bl = '{8'h55, 8'h0F, 8'hFF};
    check_tx_trace("tx2", bl, c1 + 1);

    // ---------------- Reset mid-frame ----------------
    bus_write(1'b0, 32'h00);
    idle(6);
    bus_read(1'b1, r);
    check("rst_mid_status", r, 32'h02);
    check("rst_mid_tx_low", usartTX, 0);
    @(negedge CLK_I);
    #2 RST_I = 1'b1;
    #1;
    check("rst_mid_tx_async", usartTX, 1);
    check("rst_mid_dat_o", DAT_O, 0);
    idle(2);
    RST_I = 1'b0;
    bus_read(1'b1, r);
    check("rst_after_status", r, 0);
    idle(FRAME);
    check("rst_after_tx_idle", usartTX, 1);

    // ---------------- RX register table ----------------
    v.op = OP_FRAME;   v.data = 8'h3C; v.stop = 1'b1; v.exp = 0;        vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h04;                                    vecs.push_back(v);
    v.op = OP_IRQ;     v.exp = 32'h1;                                     vecs.push_back(v);
    v.op = OP_RD_DATA; v.exp = 32'h3C;                                    vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h00;                                    vecs.push_back(v);
    v.op = OP_IRQ;     v.exp = 32'h0;                                     vecs.push_back(v);
    v.op = OP_FRAME;   v.data = 8'h11; v.stop = 1'b1;                     vecs.push_back(v);
    v.op = OP_FRAME;   v.data = 8'h22; v.stop = 1'b1;                     vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h0C;                                    vecs.push_back(v);
    v.op = OP_RD_DATA; v.exp = 32'h11;                                    vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h08;                                    vecs.push_back(v);
    v.op = OP_FRAME;   v.data = 8'h44; v.stop = 1'b0;                     vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h18;                                    vecs.push_back(v);
    v.op = OP_FRAME;   v.data = 8'h66; v.stop = 1'b1;                     vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h1C;                                    vecs.push_back(v);
    v.op = OP_FRAME;   v.data = 8'h77; v.stop = 1'b0;                     vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h1C;                                    vecs.push_back(v);
    v.op = OP_WR_STAT; v.exp = 32'h18;                                    vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h04;                                    vecs.push_back(v);
    v.op = OP_RD_DATA; v.exp = 32'h66;                                    vecs.push_back(v);
    v.op = OP_RD_STAT; v.exp = 32'h00;                                    vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_FRAME: send_frame(vecs[i].data, vecs[i].stop);
        OP_IRQ:   check($sformatf("rx_vec%0d_irq", i), rxirq, vecs[i].exp);
        OP_WR_STAT: begin
          bus_write(1'b1, vecs[i].exp);
          @(negedge CLK_I);
          check($sformatf("rx_vec%0d_ack_one_cycle", i), ACK_O, 0);
        end
        default: begin
          bus_read((vecs[i].op == OP_RD_STAT), r);
          check($sformatf("rx_vec%0d_read", i), r, vecs[i].exp);
          @(negedge CLK_I);
          check($sformatf("rx_vec%0d_ack_one_cycle", i), ACK_O, 0);
        end
      endcase
    end

    m_rxbuf = 8'h66; m_rxvalid = 1'b0; m_overrun = 1'b0; m_framerr = 1'b0;

    // ---------------- RX glitch ----------------
    @(negedge CLK_I) usartRX = 1'b0;
    @(negedge CLK_I) usartRX = 1'b1;
    idle(3 * CLKDIV);
    bus_read(1'b1, r);
    check("glitch_status", r, 0);
    check("glitch_rxirq", rxirq, 0);
    bus_read(1'b0, r);
    check("glitch_rxbuf", r, 32'h66);

    // ---------------- Randomized RX traffic ----------------
    for (int it = 0; it < 30; it++) begin
      int op;
      logic [7:0] b;
      logic s;
      logic [31:0] wv;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          b = 8'($urandom);
          s = ($urandom_range(0, 4) != 0);
          send_frame(b, s);
          model_frame(b, s);
          $display("rand%0d frame byte=0x%02h stop=%0d", it, b, s);
        end
        1: begin
          bus_read(1'b0, r);
          check($sformatf("rand%0d_data", it), r, {24'h0, m_rxbuf});
          m_rxvalid = 1'b0;
        end
        2: begin
          bus_read(1'b1, r);
          check($sformatf("rand%0d_status", it), r, model_status());
        end
        default: begin
          wv = 32'($urandom_range(0, 3)) << 3;
          bus_write(1'b1, wv);
          if (wv[3]) m_overrun = 1'b0;
          if (wv[4]) m_framerr = 1'b0;
          $display("rand%0d status write 0x%02h", it, wv[7:0]);
        end
      endcase
    end
    bus_read(1'b1, r);
    check("rand_final_status", r, model_status());
    check("rand_final_irq", rxirq, m_rxvalid);

    // ---------------- Randomized TX burst ----------------
    tr_cyc.delete(); tr_bit.delete();
    bl.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) bl.push_back(u8_t'($urandom));
    wb(1'b1, 1'b0, {24'h0, bl[0]}, r, w, c1);
    for (int i = 1; i < 3; i++) bus_write(1'b0, {24'h0, bl[i]});
    idle(3 * FRAME + 4);
    mon_en = 1'b0;
    check_tx_trace("txrand", bl, c1 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
